sequenced_decoder: RTL and testbench

Parametrised, registered binary-to-one-hot decoder; successor to the 2-to-4 enable decoder. Generalises address width and output count, and adds a registered output and a load/ready handshake. Adds an autonomous scan mode that walks the active output through every index with a programmable dwell time. Drives select lines for muxed peripherals, register-file write enables and LED/row scanning.

---
 rtl/sequenced_decoder.sv | 107 ++++++++++
 tb/tb_sequenced_decoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenced_decoder.sv
// Registered binary-to-one-hot decoder with load/ready handshake
// and an autonomous scan mode with programmable dwell.
module sequenced_decoder #(
  parameter int ADDR_WIDTH  = 2,
  parameter int NUM_OUTPUTS = 1 << ADDR_WIDTH,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   load,
  output logic                   ready,
  input  logic [ADDR_WIDTH-1:0]  address,
  input  logic                   start_scan,
  input  logic                   stop,
  input  logic [DWELL_WIDTH-1:0] dwell,
  output logic [NUM_OUTPUTS-1:0] out,
  output logic                   busy,
  output logic                   wrap,
  output logic                   err
);

  localparam int AW1 = ADDR_WIDTH + 1;
  localparam logic [AW1-1:0] LIMIT = AW1'(NUM_OUTPUTS);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(NUM_OUTPUTS - 1);
  localparam logic [NUM_OUTPUTS-1:0] ONE = NUM_OUTPUTS'(1);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SCAN
  } state_t;

  state_t                 state, next_state;
  logic [ADDR_WIDTH-1:0]  cur, next_cur;
  logic [DWELL_WIDTH-1:0] dwell_reg, next_dwell;
  logic [DWELL_WIDTH-1:0] cnt, next_cnt;
  logic [NUM_OUTPUTS-1:0] next_out;
  logic                   next_wrap, next_err;
  logic                   accept;

  assign busy  = (state == SCAN);
  assign ready = (state != SCAN);

  always_comb begin
    next_state = state;
    next_cur   = cur;
    next_dwell = dwell_reg;
    next_cnt   = cnt;
    next_wrap  = 1'b0;
    next_err   = 1'b0;
    accept     = load && (state != SCAN);
    if (stop) begin
      next_state = IDLE;
    end else if (accept) begin
      // Out-of-range loads are consumed but leave state untouched
      if ({1'b0, address} < LIMIT) begin
        next_cur   = address;
        next_state = DIRECT;
      end else begin
        next_err = 1'b1;
      end
    end else if (start_scan) begin
      next_state = SCAN;
      next_cur   = '0;
      next_dwell = dwell;
      next_cnt   = dwell;
    end else if (state == SCAN) begin
      if (cnt == '0) begin
        next_cnt = dwell_reg;
        if (cur == LAST) begin
          next_cur  = '0;
          next_wrap = 1'b1;
        end else begin
          next_cur = cur + ADDR_WIDTH'(1);
        end
      end else begin
        next_cnt = cnt - DWELL_WIDTH'(1);
      end
    end
    next_out = '0;
    if (next_state != IDLE && enable)
      next_out = ONE << next_cur;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cur       <= '0;
      dwell_reg <= '0;
      cnt       <= '0;
      out       <= '0;
      wrap      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= next_state;
      cur       <= next_cur;
      dwell_reg <= next_dwell;
      cnt       <= next_cnt;
      out       <= next_out;
      wrap      <= next_wrap;
      err       <= next_err;
    end
  end

endmodule

// File: tb/tb_sequenced_decoder.sv
// Scoreboard bench for sequenced_decoder: default 4-output
// instance plus a 3-output instance for out-of-range loads.
module tb_sequenced_decoder;

  typedef struct packed {
    logic [3:0] out;
    logic       wrap;
    logic       err;
    logic       busy;
    logic       ready;
  } exp_t;

  typedef struct packed {
    logic       en;
    logic       ld;
    logic [1:0] a;
    logic       ss;
    logic       sp;
    logic [7:0] dw;
    exp_t       e;
  } stim_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b1;
  logic       load = 1'b0;
  logic [1:0] address = '0;
  logic       start_scan = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] dwell = '0;

  logic       ready_a, busy_a, wrap_a, err_a;
  logic [3:0] out_a;
  logic       ready_b, busy_b, wrap_b, err_b;
  logic [2:0] out_b;

  int n_checks = 0;
  int n_fail = 0;

  exp_t  sb[$];
  stim_t stims[$];

  always #5 clk = ~clk;

  sequenced_decoder u_a (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .load(load), .ready(ready_a), .address(address),
    .start_scan(start_scan), .stop(stop), .dwell(dwell),
    .out(out_a), .busy(busy_a), .wrap(wrap_a), .err(err_a)
  );

  sequenced_decoder #(
    .ADDR_WIDTH(2), .NUM_OUTPUTS(3), .DWELL_WIDTH(8)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .load(load), .ready(ready_b), .address(address),
    .start_scan(start_scan), .stop(stop), .dwell(dwell),
    .out(out_b), .busy(busy_b), .wrap(wrap_b), .err(err_b)
  );

  function automatic exp_t mk(input logic [3:0] o,
    input logic w, input logic e, input logic b,
    input logic r);
    exp_t x;
    x.out = o; x.wrap = w; x.err = e;
    x.busy = b; x.ready = r;
    return x;
  endfunction

  function automatic stim_t st(input logic en,
    input logic ld, input logic [1:0] a, input logic ss,
    input logic sp, input logic [7:0] dw, input exp_t e);
    stim_t s;
    s.en = en; s.ld = ld; s.a = a; s.ss = ss;
    s.sp = sp; s.dw = dw; s.e = e;
    return s;
  endfunction

  function automatic exp_t obs_a();
    return mk(out_a, wrap_a, err_a, busy_a, ready_a);
  endfunction

  function automatic exp_t obs_b();
    return mk({1'b0, out_b}, wrap_b, err_b, busy_b, ready_b);
  endfunction

  task automatic apply(input stim_t s);
    enable = s.en; load = s.ld; address = s.a;
    start_scan = s.ss; stop = s.sp; dwell = s.dw;
  endtask

  task automatic idle_in();
    load = 1'b0; start_scan = 1'b0; stop = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got, e;
    reset_n = 1'b0;
    #2;
    sb.push_back(mk(4'b0000, 0, 0, 0, 1));
    sb.push_back(mk(4'b0000, 0, 0, 0, 1));
    got = obs_a(); e = sb.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_a got %b exp %b", got, e);
    end
    got = obs_b(); e = sb.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL reset_b got %b exp %b", got, e);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_direct();
    stim_t s;
    exp_t got, e;
    logic [3:0] v;
    for (int a = 0; a < 4; a++) begin
      v = 4'b0001 << a;
      stims.push_back(st(1, 1, 2'(a), 0, 0, 0,
        mk(v, 0, 0, 0, 1)));
    end
    stims.push_back(st(1, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1)));
    for (int i = 0; stims.size() > 0; i++) begin
      s = stims.pop_front();
      @(negedge clk);
      apply(s);
      sb.push_back(s.e);
      @(posedge clk);
      #1;
      got = obs_a(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL direct[%0d] got %b exp %b", i, got, e);
      end
    end
  endtask

  task automatic test_enable();
    stim_t s;
    exp_t got, e;
    for (int a = 0; a < 4; a++)
      stims.push_back(st(0, 1, 2'(a), 0, 0, 0,
        mk(0, 0, 0, 0, 1)));
    stims.push_back(st(0, 1, 2, 0, 0, 0, mk(0, 0, 0, 0, 1)));
    stims.push_back(st(1, 1, 2, 0, 0, 0,
      mk(4'b0100, 0, 0, 0, 1)));
    stims.push_back(st(1, 0, 0, 0, 1, 0, mk(0, 0, 0, 0, 1)));
    for (int i = 0; stims.size() > 0; i++) begin
      s = stims.pop_front();
      @(negedge clk);
      apply(s);
      sb.push_back(s.e);
      @(posedge clk);
      #1;
      got = obs_a(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL enable[%0d] got %b exp %b", i, got, e);
      end
    end
  endtask

  task automatic test_scan();
    stim_t s;
    exp_t got, e;
    logic [3:0] v;
    int idx;
    // dwell 2: each index held three cycles, loads ignored
    for (int k = 0; k < 14; k++) begin
      idx = (k / 3) % 4;
      v = 4'b0001 << idx;
      stims.push_back(st(1, (k % 2) == 1, 3, k == 0, 0, 2,
        mk(v, k == 12, 0, 1, 0)));
    end
    stims.push_back(st(1, 1, 1, 0, 1, 0, mk(0, 0, 0, 0, 1)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 1)));
    for (int i = 0; stims.size() > 0; i++) begin
      s = stims.pop_front();
      @(negedge clk);
      apply(s);
      sb.push_back(s.e);
      @(posedge clk);
      #1;
      got = obs_a(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL scan[%0d] got %b exp %b", i, got, e);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    stim_t s;
    exp_t got, e;
    stims.push_back(st(1, 0, 0, 1, 0, 0,
      mk(4'b0001, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0,
      mk(4'b0010, 0, 0, 1, 0)));
    for (int i = 0; stims.size() > 0; i++) begin
      s = stims.pop_front();
      @(negedge clk);
      apply(s);
      sb.push_back(s.e);
      @(posedge clk);
      #1;
      got = obs_a(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rstscan[%0d] got %b exp %b", i, got, e);
      end
    end
    @(negedge clk);
    reset_n = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 1));
    #1;
    got = obs_a(); e = sb.pop_front(); n_checks++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL rstscan_async got %b exp %b", got, e);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle_in();
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(0, 0, 0, 0, 1));
      @(posedge clk);
      #1;
      got = obs_a(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL rstscan_idle[%0d] got %b exp %b",
          i, got, e);
      end
    end
  endtask

  task automatic test_num3();
    stim_t s;
    exp_t got, e;
    @(negedge clk);
    reset_n = 1'b0;
    idle_in();
    @(negedge clk);
    reset_n = 1'b1;
    stims.push_back(st(1, 1, 1, 0, 0, 0, mk(4'b0010, 0, 0, 0, 1)));
    stims.push_back(st(1, 1, 3, 0, 0, 0, mk(4'b0010, 0, 1, 0, 1)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0010, 0, 0, 0, 1)));
    stims.push_back(st(1, 0, 0, 0, 1, 0, mk(4'b0000, 0, 0, 0, 1)));
    stims.push_back(st(1, 1, 3, 0, 0, 0, mk(4'b0000, 0, 1, 0, 1)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0000, 0, 0, 0, 1)));
    stims.push_back(st(1, 0, 0, 1, 0, 0, mk(4'b0001, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0010, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0100, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0001, 1, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0010, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 1, 0, mk(4'b0000, 0, 0, 0, 1)));
    for (int i = 0; stims.size() > 0; i++) begin
      s = stims.pop_front();
      @(negedge clk);
      apply(s);
      sb.push_back(s.e);
      @(posedge clk);
      #1;
      got = obs_b(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL num3[%0d] got %b exp %b", i, got, e);
      end
    end
  endtask

  task automatic test_back_to_back_scan();
    stim_t s;
    exp_t got, e;
    @(negedge clk);
    reset_n = 1'b0;
    idle_in();
    @(negedge clk);
    reset_n = 1'b1;
    stims.push_back(st(1, 1, 1, 0, 0, 0, mk(4'b0010, 0, 0, 0, 1)));
    stims.push_back(st(1, 0, 0, 1, 0, 5, mk(4'b0001, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0001, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0001, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 1, 0, 0, mk(4'b0001, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0010, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0100, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b1000, 0, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 0, 0, mk(4'b0001, 1, 0, 1, 0)));
    stims.push_back(st(1, 0, 0, 0, 1, 0, mk(4'b0000, 0, 0, 0, 1)));
    for (int i = 0; stims.size() > 0; i++) begin
      s = stims.pop_front();
      @(negedge clk);
      apply(s);
      sb.push_back(s.e);
      @(posedge clk);
      #1;
      got = obs_a(); e = sb.pop_front(); n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL restart[%0d] got %b exp %b", i, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_enable();
    test_scan();
    test_reset_mid_scan();
    test_num3();
    test_back_to_back_scan();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_left got %0d exp 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
      n_checks, n_fail);
    $finish;
  end

endmodule
